// File: rtl/native_arb_pkg.sv
// rtl/native_arb_pkg.sv - shared state encodings and sizing helper for the native packet arbiters
package native_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width for a pointer over `value` entries; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick: first request above ptr, wrapping
module rr_priority_picker
  import native_arb_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int PtrW     = clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] req,
  input  logic [PtrW-1:0]     ptr,
  output logic [NumPorts-1:0] pick,
  output logic [PtrW-1:0]     pick_idx
);

  always_comb begin
    int   cand;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    // ptr itself is scanned last, so the previous owner has lowest priority
    for (int k = 1; k <= NumPorts; k++) begin
      cand = (int'(ptr) + k) % NumPorts;
      if (!found && req[cand[PtrW-1:0]]) begin
        found                  = 1'b1;
        pick[cand[PtrW-1:0]]   = 1'b1;
        pick_idx               = cand[PtrW-1:0];
      end
    end
  end

endmodule

// File: rtl/native_rr_packet_arbiter.sv
// rtl/native_rr_packet_arbiter.sv - packet round-robin arbiter onto one native channel; NATIVE_ARB_BEAT_INTERLEAVE_EN selects beat interleave
module native_rr_packet_arbiter
  import native_arb_pkg::*;
#(
  parameter int NumPorts    = 4,
  parameter int STDataWidth = 32,
  parameter int TidWidth    = 8,
  parameter int TdestWidth  = 8
) (
  input  logic                            aclk,
  input  logic                            rst,
  input  logic [NumPorts*TidWidth-1:0]    s_axis_tid,
  input  logic [NumPorts*TdestWidth-1:0]  s_axis_tdest,
  input  logic [NumPorts*STDataWidth-1:0] s_axis_tdata,
  input  logic [NumPorts-1:0]             s_axis_tvalid,
  input  logic [NumPorts-1:0]             s_axis_tlast,
  output logic [NumPorts-1:0]             s_axis_tready,
  output logic [TidWidth-1:0]             m_native_tid,
  output logic [TdestWidth-1:0]           m_native_tdest,
  output logic [STDataWidth-1:0]          m_native_tdata,
  output logic                            m_native_tlast,
  output logic                            m_native_tvalid,
  input  logic                            m_native_tready,
  output logic [NumPorts-1:0]             grant,
  output logic                            busy
);

  localparam int PtrW = clog2(NumPorts);

  arb_state_e              state;
  logic [PtrW-1:0]         last_ptr;
  logic [PtrW-1:0]         owner_idx;
  logic [NumPorts-1:0]     pick;
  logic [PtrW-1:0]         pick_idx;
  logic                    can_load;
  logic                    accept;
  logic                    pkt_end;
  logic [TidWidth-1:0]     sel_tid;
  logic [TdestWidth-1:0]   sel_tdest;
  logic [STDataWidth-1:0]  sel_tdata;
  logic                    sel_tlast;

  rr_priority_picker #(
    .NumPorts (NumPorts),
    .PtrW     (PtrW)
  ) u_picker (
    .req      (s_axis_tvalid),
    .ptr      (last_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign busy          = (state == ARB_LOCKED);
  assign can_load      = ~m_native_tvalid | m_native_tready;
  assign s_axis_tready = busy ? (grant & {NumPorts{can_load}}) : '0;
  assign accept        = |(s_axis_tvalid & s_axis_tready);

  // grant is one-hot, so an AND-OR select is enough
  always_comb begin
    sel_tid   = '0;
    sel_tdest = '0;
    sel_tdata = '0;
    sel_tlast = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (grant[i]) begin
        sel_tid   = s_axis_tid[i*TidWidth +: TidWidth];
        sel_tdest = s_axis_tdest[i*TdestWidth +: TdestWidth];
        sel_tdata = s_axis_tdata[i*STDataWidth +: STDataWidth];
        sel_tlast = s_axis_tlast[i];
      end
    end
  end

`ifdef NATIVE_ARB_BEAT_INTERLEAVE_EN
  assign pkt_end = 1'b1;
`else
  assign pkt_end = sel_tlast;
`endif

  always_ff @(posedge aclk) begin
    if (rst) begin
      state           <= ARB_IDLE;
      grant           <= '0;
      owner_idx       <= '0;
      last_ptr        <= PtrW'(NumPorts - 1);
      m_native_tvalid <= 1'b0;
      m_native_tid    <= '0;
      m_native_tdest  <= '0;
      m_native_tdata  <= '0;
      m_native_tlast  <= 1'b0;
    end else begin
      if (state == ARB_IDLE) begin
        if (|s_axis_tvalid) begin
          grant     <= pick;
          owner_idx <= pick_idx;
          state     <= ARB_LOCKED;
        end
      end else if (accept && pkt_end) begin
        last_ptr <= owner_idx;
        grant    <= '0;
        state    <= ARB_IDLE;
      end

      if (accept) begin
        m_native_tvalid <= 1'b1;
        m_native_tid    <= sel_tid;
        m_native_tdest  <= sel_tdest;
        m_native_tdata  <= sel_tdata;
        m_native_tlast  <= sel_tlast;
      end else if (m_native_tready) begin
        m_native_tvalid <= 1'b0;
      end
    end
  end

endmodule
